// File: rtl/codec_init_seq_pkg.sv
// Shared types and constants for the SSM2603 codec init sequencer.
// Defines the table entry, device/register addresses and FSM state encoding.
package codec_pkg;

   localparam logic [6:0] SSM2603_DEV_ADDR = 7'h1A;

   localparam logic [6:0] R_LIN   = 7'h00;
   localparam logic [6:0] R_RIN   = 7'h01;
   localparam logic [6:0] R_LHP   = 7'h02;
   localparam logic [6:0] R_RHP   = 7'h03;
   localparam logic [6:0] R_APATH = 7'h04;
   localparam logic [6:0] R_DPATH = 7'h05;
   localparam logic [6:0] R_PWR   = 7'h06;
   localparam logic [6:0] R_DIF   = 7'h07;
   localparam logic [6:0] R_SR    = 7'h08;
   localparam logic [6:0] R_ACT   = 7'h09;
   localparam logic [6:0] R_RESET = 7'h0F;

   typedef struct packed {
      logic       dly;
      logic [6:0] addr;
      logic [8:0] data;
   } init_entry_t;

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_LOAD,
      ST_ISSUE,
      ST_WAIT_RSP,
      ST_SETTLE,
      ST_NEXT,
      ST_DONE,
      ST_ERROR
   } init_state_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/codec_init_seq_if.sv
// Command/response channel between the init sequencer and the I2C master.
interface codec_init_seq_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [6:0] cmd_dev_addr;
   logic [7:0] cmd_byte0;
   logic [7:0] cmd_byte1;
   logic       rsp_valid;
   logic       rsp_nack;

   modport master (
      output cmd_valid, cmd_dev_addr, cmd_byte0, cmd_byte1,
      input  cmd_ready, rsp_valid, rsp_nack
   );

   modport slave (
      input  cmd_valid, cmd_dev_addr, cmd_byte0, cmd_byte1,
      output cmd_ready, rsp_valid, rsp_nack
   );

endinterface

// File: rtl/codec_init_seq_rom.sv
// Fixed SSM2603 power-up register table; purely combinational lookup.
module codec_init_rom
   import codec_pkg::*;
#(
   parameter int unsigned IDX_W = 4
) (
   input  logic [IDX_W-1:0] idx,
   output init_entry_t      entry
);

   // Reset first (with settle), power up core blocks, program paths, activate, then outputs on.
   always_comb begin
      entry = '0;
      case (int'(idx))
         0:  entry = '{1'b1, R_RESET, 9'h000};
         1:  entry = '{1'b0, R_PWR,   9'h072};
         2:  entry = '{1'b0, R_LIN,   9'h017};
         3:  entry = '{1'b0, R_RIN,   9'h017};
         4:  entry = '{1'b0, R_LHP,   9'h079};
         5:  entry = '{1'b0, R_RHP,   9'h079};
         6:  entry = '{1'b0, R_APATH, 9'h012};
         7:  entry = '{1'b0, R_DPATH, 9'h000};
         8:  entry = '{1'b0, R_DIF,   9'h00A};
         9:  entry = '{1'b0, R_SR,    9'h000};
         10: entry = '{1'b1, R_ACT,   9'h001};
         11: entry = '{1'b0, R_PWR,   9'h062};
         default: entry = '0;
      endcase
   end

endmodule

// File: rtl/codec_init_seq.sv
// Walks the SSM2603 init table after reset, one 3-byte I2C write per entry.
// Optional macro CODEC_INIT_RETRY_EN: retry NACK/timeout up to MAX_RETRY times per entry.
module codec_init_seq
   import codec_pkg::*;
#(
   parameter int unsigned NUM_REGS       = 12,
   parameter int unsigned POWERUP_CYCLES = 12_500_000,
   parameter int unsigned DELAY_CYCLES   = 6_250_000,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        restart,
   codec_init_seq_if.master            cmd,
   output logic                        busy,
   output logic                        init_done,
   output logic                        init_err,
   output logic [$clog2(NUM_REGS)-1:0] err_index
);

   localparam int unsigned IDX_W   = $clog2(NUM_REGS);
   localparam int unsigned CNT_MAX = max3(POWERUP_CYCLES, DELAY_CYCLES, TIMEOUT_CYCLES);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   if (NUM_REGS < 2 || POWERUP_CYCLES == 0 || DELAY_CYCLES == 0 ||
       TIMEOUT_CYCLES == 0 || MAX_RETRY > 255) begin : g_bad_param
      $error("codec_init_seq: unsupported parameter set");
   end

   init_state_t      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dly_q, dly_d;
   logic [7:0]       byte0_q, byte0_d;
   logic [7:0]       byte1_q, byte1_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [IDX_W-1:0] err_idx_q, err_idx_d;
   logic             fail;
   init_entry_t      rom_entry;

`ifdef CODEC_INIT_RETRY_EN
   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1) > 0 ? $clog2(MAX_RETRY + 1) : 1;
   logic [RETRY_W-1:0] retry_q, retry_d;
`endif

   codec_init_rom #(.IDX_W(IDX_W)) u_rom (
      .idx   (idx_q),
      .entry (rom_entry)
   );

   // Next-state and next-output logic; outputs are registered from the next state.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      dly_d   = dly_q;
      byte0_d = byte0_q;
      byte1_d = byte1_q;
      fail    = 1'b0;
`ifdef CODEC_INIT_RETRY_EN
      retry_d = retry_q;
`endif

      case (state_q)
         ST_POWERUP: begin
            if (cnt_q == CNT_W'(POWERUP_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = ST_LOAD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_LOAD: begin
            byte0_d = {rom_entry.addr, rom_entry.data[8]};
            byte1_d = rom_entry.data[7:0];
            dly_d   = rom_entry.dly;
`ifdef CODEC_INIT_RETRY_EN
            retry_d = '0;
`endif
            state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (valid_q && cmd.cmd_ready) begin
               cnt_d   = '0;
               state_d = ST_WAIT_RSP;
            end
         end
         ST_WAIT_RSP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cmd.rsp_valid && !cmd.rsp_nack) begin
               cnt_d   = '0;
               state_d = dly_q ? ST_SETTLE : ST_NEXT;
            end else if (cmd.rsp_valid || cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               fail = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == CNT_W'(DELAY_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = ST_NEXT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_NEXT: begin
            if (idx_q == IDX_W'(NUM_REGS - 1)) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = ST_LOAD;
            end
         end
         ST_DONE, ST_ERROR: begin
            if (restart) begin
               idx_d   = '0;
               cnt_d   = '0;
               state_d = ST_LOAD;
            end
         end
      endcase

      // NACK or timeout: retry the same entry while budget remains, else abort.
      if (fail) begin
`ifdef CODEC_INIT_RETRY_EN
         if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_ISSUE;
         end else begin
            state_d = ST_ERROR;
         end
`else
         state_d = ST_ERROR;
`endif
      end

      valid_d   = (state_d == ST_ISSUE);
      busy_d    = !(state_d inside {ST_DONE, ST_ERROR});
      done_d    = (state_d == ST_DONE);
      err_d     = (state_d == ST_ERROR);
      err_idx_d = (state_d == ST_ERROR) ? idx_q : '0;
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_POWERUP;
         idx_q     <= '0;
         cnt_q     <= '0;
         dly_q     <= 1'b0;
         byte0_q   <= '0;
         byte1_q   <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_idx_q <= '0;
`ifdef CODEC_INIT_RETRY_EN
         retry_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         dly_q     <= dly_d;
         byte0_q   <= byte0_d;
         byte1_q   <= byte1_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_idx_q <= err_idx_d;
`ifdef CODEC_INIT_RETRY_EN
         retry_q   <= retry_d;
`endif
      end
   end

   assign cmd.cmd_valid    = valid_q;
   assign cmd.cmd_dev_addr = SSM2603_DEV_ADDR;
   assign cmd.cmd_byte0    = byte0_q;
   assign cmd.cmd_byte1    = byte1_q;
   assign busy             = busy_q;
   assign init_done        = done_q;
   assign init_err         = err_q;
   assign err_index        = err_idx_q;

endmodule
